// File: rtl/uart_rx_param.sv
// uart_rx_param - parametrised oversampling UART receiver.
//
// Decodes start / DATA_BITS data (LSB first) / optional parity / STOP_BITS
// stop frames from UART_RX, majority-votes three samples around mid-bit for
// data and parity, and hands bytes to the consumer over a valid/ready
// handshake with first-word-fall-through storage.
//
// Optional feature macro: UART_RX_FIFO_EN
//   defined   : FIFO_DEPTH-entry circular receive FIFO
//   undefined : single holding register
//
// Ports
//   sysclk      system clock, rising edge
//   reset       asynchronous active-low reset
//   UART_RX     serial line, idles high
//   rx_data     head byte, bit 0 = first received data bit
//   rx_valid    rx_data holds a byte
//   rx_ready    consumer accepts the head byte when high with rx_valid
//   rx_count    bytes held
//   rx_busy     a frame is in progress
//   frame_err   1-cycle pulse, stop bit sampled low
//   parity_err  1-cycle pulse, parity mismatch on a stored/overrun byte
//   overrun     1-cycle pulse, completed byte dropped because storage is full
module uart_rx_param #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          sysclk,
    input  logic                          reset,
    input  logic                          UART_RX,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          rx_busy,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TW    = $clog2(OVERSAMPLE + 1);
    localparam int unsigned BW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TW-1:0]    T_PRE     = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]    T_MID     = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0]    T_POST    = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0]    T_END     = TW'(OVERSAMPLE);
    localparam logic [BW-1:0]    LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);
    localparam logic             PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state, state_n;

    logic                 rx_s1, rx_s2, rx_q;
    logic [DIV_W-1:0]     div_cnt;
    logic [TW-1:0]        tick_cnt, tick_idx;
    logic                 tick, at_pre, at_mid, at_post, at_end;
    logic                 s_a, s_b, vote;
    logic [DATA_BITS-1:0] data_sr;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 par_bad;
    logic                 push_req, ferr_set, shift_en, par_en;
    logic                 full, push_ok, pop;

    // Two-flop synchroniser plus one delayed copy for falling-edge detect.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_q  <= 1'b1;
        end else begin
            rx_s1 <= UART_RX;
            rx_s2 <= rx_s1;
            rx_q  <= rx_s2;
        end
    end

    // tick_idx is the 1-based number of the tick now occurring within the bit.
    assign tick     = (div_cnt == DIV_LAST);
    assign tick_idx = tick_cnt + TW'(1);
    assign at_pre   = tick && (tick_idx == T_PRE);
    assign at_mid   = tick && (tick_idx == T_MID);
    assign at_post  = tick && (tick_idx == T_POST);
    assign at_end   = tick && (tick_idx == T_END);
    assign vote     = (s_a & s_b) | (s_a & rx_s2) | (s_b & rx_s2);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else if (state == S_IDLE) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else if (tick) begin
            div_cnt  <= '0;
            tick_cnt <= (tick_idx == T_END) ? '0 : tick_idx;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // START is held until the end of the start bit (after the mid-bit check)
    // so every later bit is counted on whole-bit boundaries.
    always_comb begin
        state_n  = state;
        push_req = 1'b0;
        ferr_set = 1'b0;
        shift_en = 1'b0;
        par_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_q && !rx_s2) state_n = S_START;
            end
            S_START: begin
                if (at_mid && rx_s2) state_n = S_IDLE;
                else if (at_end)     state_n = S_DATA;
            end
            S_DATA: begin
                shift_en = at_post;
                if (at_end && bit_idx == LAST_BIT)
                    state_n = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                par_en = at_post;
                if (at_end) state_n = S_STOP;
            end
            S_STOP: begin
                if (at_mid) begin
                    if (!rx_s2) begin
                        ferr_set = 1'b1;
                        state_n  = S_BREAK;
                    end else if (stop_idx == LAST_STOP) begin
                        push_req = 1'b1;
                        state_n  = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s2) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign rx_busy = (state != S_IDLE);
    assign pop     = rx_valid && rx_ready;
    assign push_ok = push_req && !full;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            s_a        <= 1'b1;
            s_b        <= 1'b1;
            data_sr    <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            par_bad    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (at_pre) s_a <= rx_s2;
            if (at_mid) s_b <= rx_s2;
            if (state == S_IDLE) begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                par_bad  <= 1'b0;
            end
            if (shift_en) data_sr <= {vote, data_sr[DATA_BITS-1:1]};
            if (state == S_DATA && at_end) bit_idx <= bit_idx + 1'b1;
            if (par_en) par_bad <= (^data_sr) ^ vote ^ PAR_ODD;
            if (state == S_STOP && at_mid && rx_s2) stop_idx <= 1'b1;
            frame_err  <= ferr_set;
            parity_err <= push_req && par_bad;
            overrun    <= push_req && full;
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;

    // Full is judged before any same-cycle pop: a pop never makes room
    // for the byte completing in that cycle.
    assign full = (count == CNT_FULL);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= data_sr;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rx_data  = mem[rd_ptr];
    assign rx_valid = (count != '0);
    assign rx_count = count;
`else
    logic [DATA_BITS-1:0] hold_reg;
    logic                 hold_valid;

    // A held byte being popped this cycle is replaced by the new one;
    // only a byte that is not being taken blocks the incoming frame.
    assign full = hold_valid && !rx_ready;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            hold_reg   <= '0;
            hold_valid <= 1'b0;
        end else if (push_ok) begin
            hold_reg   <= data_sr;
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign rx_data  = hold_reg;
    assign rx_valid = hold_valid;

    always_comb begin
        rx_count    = '0;
        rx_count[0] = hold_valid;
    end
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int unsigned CLK_FREQ = 640000;
    localparam int unsigned BAUD     = 10000;
    localparam int unsigned OS       = 16;
    localparam int unsigned DB       = 8;
    localparam int unsigned FD       = 4;
    localparam int unsigned DIVC     = CLK_FREQ / (BAUD * OS);
    localparam int unsigned BIT      = DIVC * OS;
    localparam int unsigned CW       = $clog2(FD) + 1;
`ifdef UART_RX_FIFO_EN
    localparam int unsigned CAP = FD;
`else
    localparam int unsigned CAP = 1;
`endif

    logic          sysclk = 1'b0;
    logic          reset = 1'b0;
    logic          UART_RX = 1'b1;
    logic          rx_ready = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic [CW-1:0] rx_count;
    logic          rx_busy, frame_err, parity_err, overrun;

    uart_rx_param #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(DB),
        .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(FD)
    ) dut (
        .sysclk(sysclk), .reset(reset), .UART_RX(UART_RX),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_count(rx_count), .rx_busy(rx_busy), .frame_err(frame_err),
        .parity_err(parity_err), .overrun(overrun)
    );

    always #5 sysclk = ~sysclk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [DB-1:0] exp_q[$];
    logic [2:0]    evt_q[$];     // {frame_err, parity_err, overrun}
    logic          lat_arm = 1'b0;
    int            lat_cyc = 0;

    always @(posedge sysclk) cyc++;

    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Scoreboard monitor: compares every handshake and every error pulse.
    always @(negedge sysclk) begin
        #1;
        if (reset) begin
            if (lat_arm && rx_valid) begin
                lat_cyc = cyc;
                lat_arm = 1'b0;
            end
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL pop_unexpected: got %0h want no byte", rx_data);
                end else begin
                    chk("pop_data", rx_data, exp_q.pop_front());
                end
            end
            if (frame_err || parity_err || overrun) begin
                if (evt_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL err_unexpected: got %b want no pulse",
                             {frame_err, parity_err, overrun});
                end else begin
                    chk("err_pulse", {frame_err, parity_err, overrun}, evt_q.pop_front());
                end
            end
        end
    end

    // Frame-level reference: what storage does with a completed frame.
    task automatic model(input logic [DB-1:0] d, input bit par_bad, input bit stop_low);
        bit is_full;
        if (stop_low) begin
            evt_q.push_back(3'b100);
        end else begin
`ifdef UART_RX_FIFO_EN
            is_full = (exp_q.size() >= FD);
`else
            is_full = (exp_q.size() >= 1) && !rx_ready;
`endif
            if (!is_full) exp_q.push_back(d);
            if (par_bad || is_full) evt_q.push_back({1'b0, par_bad, is_full});
        end
    endtask

    task automatic hold(input logic v, input int unsigned n);
        UART_RX = v;
        repeat (n) @(negedge sysclk);
    endtask

    // glitch_bit: 0..7 data bit, 8 parity bit, -1 none. The glitch hits only
    // the first of the three votes.
    task automatic send(input logic [DB-1:0] d, input bit par_flip,
                        input bit stop_low, input int glitch_bit);
        logic [DB:0] bits;
        bits = {(^d) ^ par_flip, d};
        hold(1'b0, BIT);
        for (int i = 0; i <= DB; i++) begin
            if (i == glitch_bit) begin
                hold(bits[i], (OS/2 - 1) * DIVC);
                hold(~bits[i], 2);
                hold(bits[i], BIT - (OS/2 - 1) * DIVC - 2);
            end else begin
                hold(bits[i], BIT);
            end
        end
        model(d, par_flip, stop_low);
        hold(~stop_low, BIT);
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: got timeout want completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int lat;
        repeat (5) @(negedge sysclk);
        chk("rst_valid", rx_valid, 0);
        chk("rst_count", rx_count, 0);
        chk("rst_busy", rx_busy, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_errs", {frame_err, parity_err, overrun}, 0);
        reset = 1'b1;
        repeat (5) @(negedge sysclk);

        // Single byte with latency from start edge to rx_valid.
        lat_arm = 1'b1;
        lat = cyc;
        send(8'h55, 0, 0, -1);
        hold(1'b1, BIT);
        lat = lat_cyc - lat;
        total++;
        if (lat < int'(BIT*10 + BIT/2 + 2) || lat > int'(BIT*10 + BIT/2 + 4)) begin
            bad++;
            $display("FAIL latency: got %0d want %0d..%0d", lat, BIT*10 + BIT/2 + 2, BIT*10 + BIT/2 + 4);
        end
        chk("after55_busy", rx_busy, 0);

        // False start.
        hold(1'b0, 6);
        chk("fs_busy_hi", rx_busy, 1);
        hold(1'b0, 14);
        hold(1'b1, BIT);
        chk("fs_busy_lo", rx_busy, 0);
        chk("fs_count", rx_count, 0);
        send(8'hA5, 0, 0, -1);
        hold(1'b1, BIT);
        chk("a5_drained", exp_q.size(), 0);

        // Framing error then long break.
        send(8'hF0, 0, 1, -1);
        hold(1'b0, 20 * BIT);
        chk("brk_busy", rx_busy, 1);
        chk("brk_count", rx_count, 0);
        hold(1'b1, BIT);
        chk("brk_idle", rx_busy, 0);
        send(8'h3C, 0, 0, -1);
        hold(1'b1, BIT);
        chk("3c_drained", exp_q.size(), 0);

        // Parity mismatch then matching parity.
        send(8'h07, 1, 0, -1);
        hold(1'b1, BIT);
        send(8'h07, 0, 0, -1);
        hold(1'b1, BIT);

        // Fill storage with the consumer stalled.
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send(DB'(i), 0, 0, -1);
            hold(1'b1, 8);
        end
        hold(1'b1, BIT);
        chk("fill_count", rx_count, (CAP < 5) ? CAP : 5);
        chk("fill_head", rx_data, 8'h01);
        chk("fill_valid", rx_valid, 1);
        rx_ready = 1'b1;
        hold(1'b1, 2 * FD + 4);
        chk("drain_count", rx_count, 0);
        chk("drain_q", exp_q.size(), 0);

        // Reset in the middle of data bit 4 with a byte held.
        rx_ready = 1'b0;
        send(8'h5A, 0, 0, -1);
        hold(1'b1, BIT);
        chk("pre_rst_count", rx_count, 1);
        hold(1'b0, BIT);
        hold(1'b1, BIT); hold(1'b1, BIT); hold(1'b0, BIT); hold(1'b1, BIT);
        hold(1'b0, BIT / 2);
        #3 reset = 1'b0;
        #1;
        chk("mid_rst_valid", rx_valid, 0);
        chk("mid_rst_count", rx_count, 0);
        chk("mid_rst_busy", rx_busy, 0);
        chk("mid_rst_data", rx_data, 0);
        exp_q.delete();
        evt_q.delete();
        @(negedge sysclk);
        hold(1'b1, 3);
        reset = 1'b1;
        rx_ready = 1'b1;
        hold(1'b1, BIT);
        send(8'h96, 0, 0, -1);
        hold(1'b1, BIT);
        chk("96_drained", exp_q.size(), 0);

        // Randomised frames: data, parity faults, framing faults, glitches,
        // and consumer stalls.
        for (int n = 0; n < 30; n++) begin
            logic [DB-1:0] d;
            bit pf, sl;
            int gb;
            d  = DB'($urandom);
            pf = ($urandom_range(0, 4) == 0);
            sl = ($urandom_range(0, 9) == 0);
            gb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DB)) : -1;
            if ($urandom_range(0, 3) == 0) rx_ready = ~rx_ready;
            send(d, pf, sl, gb);
            hold(1'b1, $urandom_range(4, BIT));
        end
        rx_ready = 1'b1;
        hold(1'b1, BIT);
        chk("rand_count", rx_count, 0);
        chk("rand_bytes_left", exp_q.size(), 0);
        chk("rand_errs_left", evt_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver for the pipeline CPU peripheral bus; successor to the fixed 9600-baud, 8N1 receive path. Oversamples `UART_RX`, decodes frames with configurable data width, parity and stop bits, flags framing/parity/overrun errors, and delivers bytes through a valid/ready handshake backed by an optional receive FIFO. Sits between the board UART pin and the CPU's memory-mapped UART registers.

## Interface
- `CLK_FREQ`, 100000000, system clock frequency in Hz.
- `BAUD`, 9600, line rate in bit/s.
- `OVERSAMPLE`, 16, sample ticks per bit; even, at least 8.
- `DATA_BITS`, 8, data bits per frame, 5..9.
- `PARITY`, 0, 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1, 1 or 2.
- `FIFO_DEPTH`, 4, receive FIFO entries; power of two, at least 2. Used only with `UART_RX_FIFO_EN`.
- `sysclk  in  1`  system clock, rising edge.
- `reset  in  1`  asynchronous, active-low reset.
- `UART_RX  in  1`  serial line, idles high.
- `rx_data  out  DATA_BITS`  head byte, LSB = first received bit.
- `rx_valid  out  1`  `rx_data` holds a valid byte.
- `rx_ready  in  1`  consumer accepts the head byte when high with `rx_valid`.
- `rx_count  out  $clog2(FIFO_DEPTH)+1`  bytes held.
- `rx_busy  out  1`  frame currently being received.
- `frame_err  out  1`  1-cycle pulse on a bad stop bit.
- `parity_err  out  1`  1-cycle pulse on a parity mismatch.
- `overrun  out  1`  1-cycle pulse when a completed byte is dropped because storage is full.

## Operation
- Tick divisor: `DIV = CLK_FREQ/(BAUD*OVERSAMPLE)`, integer truncation; defaults give 651 (1 bit = 10416 cycles). The tick counter runs only outside IDLE and restarts at the start edge.
- `UART_RX` passes through a 2-flop synchroniser (reset value 1) before any use.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: synchronised falling edge -> START, `rx_busy` = 1.
  - START: at tick OVERSAMPLE/2 the line is low -> DATA; the line is high -> false start, IDLE.
  - DATA: one bit per OVERSAMPLE ticks. Each bit is the majority of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. LSB first. After DATA_BITS bits go to PARITY when PARITY≠0, otherwise STOP.
  - PARITY: sample with the same majority vote. A mismatch is flagged and the byte is still stored.
  - STOP: sample each stop bit. Any stop bit low -> `frame_err` pulse, byte discarded, go to BREAK. All stop bits high -> store the byte (or pulse `overrun` if full) and `parity_err` if flagged, then go to IDLE at mid-stop-bit.
  - BREAK: wait for the synchronised line to be high -> IDLE.
- Handshake: pop occurs when `rx_valid && rx_ready`. `rx_data` stays stable while `rx_valid && !rx_ready`. A push and a pop in the same cycle are both honoured and `rx_count` is unchanged. A push into full storage is refused even if a pop occurs the same cycle; `overrun` pulses.
- Error pulses are mutually exclusive per frame except `parity_err` with `overrun`, which may occur together.

## Timing
- Reset (async assert, release on next clock): `rx_data`=0, `rx_valid`=0, `rx_count`=0, `rx_busy`=0, all error pulses 0, FSM in IDLE, storage empty. Reset mid-frame abandons the frame.
- Start-edge detect latency is 2 cycles (synchroniser).
- Byte visible on `rx_valid` 1 cycle after the mid-stop-bit sample. For 8N1 at the defaults this is ≈9.5 bit times + 3 cycles after the line falls.
- `rx_busy` falls in the same cycle the byte is pushed.
- Head-of-FIFO data is first-word-fall-through: no extra read latency.

## Configuration
- `UART_RX_FIFO_EN` defined: a circular FIFO of FIFO_DEPTH entries with wrap-around read/write pointers; `rx_count` ranges 0..FIFO_DEPTH.
- Not defined: a single holding register; `rx_count` is 0 or 1; `overrun` fires on any byte completing while `rx_valid && !rx_ready`.

## Test plan
- Defaults, `rx_ready`=1, send 0x55 8N1 at 104167 ns/bit -> `rx_valid` pulses with `rx_data`=0x55 ≈989.6 µs after the start edge; no error pulses.
- `UART_RX_FIFO_EN` defined, `rx_ready`=0, send 0x01..0x05 -> `rx_count`=4, `overrun` pulses once on 0x05; then `rx_ready`=1 pops 0x01, 0x02, 0x03, 0x04 in order, and `rx_count` reaches 0.
- Line low for 3000 ns then high -> false start; no `rx_valid`, `rx_busy` returns to 0, and the next 0xA5 frame is received correctly.
- Stop bit driven low, line then held low for 2 ms -> one `frame_err` pulse, no push, no further frames until the line goes high; the following 0x3C frame is received.
- PARITY=1 (even), send 0x07 with parity bit 0 -> `rx_data`=0x07 stored and `parity_err` pulses; with parity bit 1 -> no error.
- Assert `reset` low in the middle of data bit 4 -> all outputs return to reset values immediately; after release, a full 0x96 frame is received correctly.
